// File: rtl/dbus_sram_resp.sv
// Data-bus SRAM responder: one outstanding request, fixed LATENCY from accept to data_ok,
// byte-strobed writes, and a saturating count of out-of-range requests.

package dbus_sram_resp_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_resp
    import dbus_sram_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic [7:0] err_cnt
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    logic [2:0]    cnt;

    logic [AW-1:0] req_idx;
    logic [3:0]    req_strobe;
    logic [31:0]   req_wdata;
    logic          req_write;
    logic          req_oor;

    logic [31:0]   rd_data;
    logic [31:0]   mem [MEM_WORDS];

    logic          enter_resp;
    logic          in_oor;
    logic [AW-1:0] in_idx;
    logic [AW-1:0] rd_idx;

    // Size and the byte offset never affect behaviour; fold them away explicitly.
    logic          unused_bits;
    assign unused_bits = ^{dreq.size, dreq.addr[1:0]};

    assign in_idx     = dreq.addr[AW+1:2];
    assign in_oor     = (dreq.addr >> (AW + 2)) != 32'd0;
    assign enter_resp = ((state == IDLE) && dreq.valid && (LATENCY == 1)) ||
                        ((state == BUSY) && (cnt == 3'd0));
    assign rd_idx     = (state == IDLE) ? in_idx : req_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_idx    <= '0;
            req_strobe <= '0;
            req_wdata  <= '0;
            req_write  <= 1'b0;
            req_oor    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq.valid) begin
                        req_idx    <= in_idx;
                        req_strobe <= dreq.strobe;
                        req_wdata  <= dreq.data;
                        req_write  <= |dreq.strobe;
                        req_oor    <= in_oor;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 3'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The store is read on the edge that enters RESP; a write only lands at the end of RESP,
    // so the word sampled here is always current for the single outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (enter_resp) begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && req_write && !req_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (req_strobe[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if ((state == RESP) && req_oor && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state == IDLE);
        dresp.data_ok = (state == RESP);
        if ((state == RESP) && !req_write && !req_oor) begin
            dresp.data = rd_data;
        end
    end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Directed bench for dbus_sram_resp: one instance at LATENCY=2 / 1024 words, one at
// LATENCY=1 / 16 words, driven one post-edge step at a time.

module tb_dbus_sram_resp;
    import dbus_sram_resp_pkg::*;

    logic       clk;
    logic       reset;
    dbus_req_t  dreq0;
    dbus_req_t  dreq1;
    dbus_resp_t dresp0;
    dbus_resp_t dresp1;
    logic [7:0] err_cnt0;
    logic [7:0] err_cnt1;

    int testCount = 0;
    int failCount = 0;

    dbus_sram_resp #(.MEM_WORDS(1024), .LATENCY(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .dreq    (dreq0),
        .dresp   (dresp0),
        .err_cnt (err_cnt0)
    );

    dbus_sram_resp #(.MEM_WORDS(16), .LATENCY(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .dreq    (dreq1),
        .dresp   (dresp1),
        .err_cnt (err_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from an idle DUT and waits for data_ok; returns in IDLE after RESP.
    task automatic applyStimulus(input bit which, input logic [31:0] addr, input logic [3:0] strobe,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int lat, output logic aok_at_resp);
        dbus_resp_t r;
        bit         got;
        int         i;
        dbus_req_t  q;
        q        = '0;
        q.valid  = 1'b1;
        q.addr   = addr;
        q.size   = 2'd2;
        q.strobe = strobe;
        q.data   = wdata;
        if (which) dreq1 = q; else dreq0 = q;
        step();
        if (which) dreq1 = '0; else dreq0 = '0;
        lat         = 0;
        rdata       = '0;
        aok_at_resp = 1'b1;
        got         = 1'b0;
        i           = 1;
        while (!got && i <= 20) begin
            r = which ? dresp1 : dresp0;
            if (r.data_ok) begin
                got         = 1'b1;
                lat         = i;
                rdata       = r.data;
                aok_at_resp = r.addr_ok;
            end
            step();
            i++;
        end
        if (!got) checkOutput("data_ok_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        aok;
        int          seen;
        dbus_req_t   q;

        dreq0 = '0;
        dreq1 = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        checkOutput("rst_addr_ok", 32'(dresp0.addr_ok), 32'd1);
        checkOutput("rst_data_ok", 32'(dresp0.data_ok), 32'd0);
        checkOutput("rst_data",    dresp0.data,          32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt0),        32'd0);
        checkOutput("rst_addr_ok1", 32'(dresp1.addr_ok), 32'd1);

        applyStimulus(0, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat, aok);
        checkOutput("wr_lat",  32'(lat), 32'd2);
        checkOutput("wr_data", rd,       32'd0);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("rd_lat",  32'(lat), 32'd2);
        checkOutput("rd_data", rd,       32'hDEADBEEF);
        applyStimulus(0, 32'h13, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("rd_offset_ignored", rd, 32'hDEADBEEF);

        applyStimulus(0, 32'h20, 4'hF, 32'h11223344, rd, lat, aok);
        applyStimulus(0, 32'h20, 4'h2, 32'h0000AA00, rd, lat, aok);
        applyStimulus(0, 32'h20, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("partial_lane1", rd, 32'h1122AA44);
        applyStimulus(0, 32'h20, 4'h9, 32'hAABBCCDD, rd, lat, aok);
        applyStimulus(0, 32'h20, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("partial_lane03", rd, 32'hAA22AADD);

        // valid held high: accepts in cycles 0, 3, 6 and data_ok in 2, 5, 8
        q       = '0;
        q.valid = 1'b1;
        q.addr  = 32'h10;
        dreq0   = q;
        for (int c = 0; c < 9; c++) begin
            checkOutput($sformatf("held_addr_ok_c%0d", c), 32'(dresp0.addr_ok), 32'((c % 3) == 0));
            checkOutput($sformatf("held_data_ok_c%0d", c), 32'(dresp0.data_ok), 32'((c % 3) == 2));
            checkOutput($sformatf("held_data_c%0d", c), dresp0.data,
                        ((c % 3) == 2) ? 32'hDEADBEEF : 32'h0);
            if (c == 8) dreq0 = '0;
            step();
        end

        applyStimulus(0, 32'h1000, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("oor_rd_lat",  32'(lat),     32'd2);
        checkOutput("oor_rd_data", rd,           32'd0);
        checkOutput("oor_err_1",   32'(err_cnt0), 32'd1);
        applyStimulus(0, 32'h1010, 4'hF, 32'h12345678, rd, lat, aok);
        checkOutput("oor_err_2", 32'(err_cnt0), 32'd2);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("oor_wr_dropped", rd, 32'hDEADBEEF);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(0, 32'h1000, 4'h0, 32'h0, rd, lat, aok);
        end
        checkOutput("oor_err_sat", 32'(err_cnt0), 32'h0FF);

        // reset in the cycle after a write is accepted
        q        = '0;
        q.valid  = 1'b1;
        q.addr   = 32'h10;
        q.strobe = 4'hF;
        q.data   = 32'h0BADF00D;
        dreq0    = q;
        step();
        dreq0 = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midrst_addr_ok", 32'(dresp0.addr_ok), 32'd1);
        checkOutput("midrst_data_ok", 32'(dresp0.data_ok), 32'd0);
        checkOutput("midrst_err_cnt", 32'(err_cnt0),       32'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (dresp0.data_ok) seen++;
            step();
        end
        checkOutput("midrst_no_data_ok", 32'(seen), 32'd0);
        applyStimulus(0, 32'h10, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("midrst_word_kept", rd, 32'hDEADBEEF);

        // reset coinciding with the RESP cycle of a write
        dreq0 = q;
        step();
        dreq0 = '0;
        step();
        checkOutput("resprst_in_resp", 32'(dresp0.data_ok), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(0, 32'h10, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("resprst_word_kept", rd, 32'hDEADBEEF);

        applyStimulus(1, 32'h8, 4'hF, 32'hCAFEF00D, rd, lat, aok);
        checkOutput("l1_wr_lat", 32'(lat), 32'd1);
        applyStimulus(1, 32'h8, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("l1_rd_lat",        32'(lat),          32'd1);
        checkOutput("l1_rd_data",       rd,                32'hCAFEF00D);
        checkOutput("l1_addr_ok_resp",  32'(aok),          32'd0);
        checkOutput("l1_addr_ok_after", 32'(dresp1.addr_ok), 32'd1);
        applyStimulus(1, 32'h40, 4'h0, 32'h0, rd, lat, aok);
        checkOutput("l1_oor_data", rd,             32'd0);
        checkOutput("l1_oor_err",  32'(err_cnt1),  32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dbus_sram_resp.md
DBUS_SRAM_RESP -- requirements
Module: dbus_sram_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning backing store depth in 32-bit words; power of two, AW = log2(MEM_WORDS).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from the accept cycle to the data_ok cycle; legal range 1..7.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dreq  input  dbus_req_t  request from the memory stage: valid, addr[31:0], size, strobe[3:0], data[31:0].
REQ-006 SHALL have port dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[31:0].
REQ-007 SHALL have port err_cnt  output  8  saturating count of out-of-range requests.

Function
REQ-008 SHALL accept a request in any cycle where dreq.valid=1 and dresp.addr_ok=1; the accept cycle is T.
REQ-009 SHALL drive dresp.addr_ok=1 only in state IDLE; combinational from state only, independent of dreq.valid.
REQ-010 SHALL keep at most one request outstanding; no accept in BUSY or RESP.
REQ-011 SHALL latch addr, strobe, and data at T; later changes on dreq SHALL NOT affect the outstanding request.
REQ-012 SHALL treat strobe!=0 as a write and strobe==0 as a read; size SHALL be ignored.
REQ-013 SHALL index the store with word index addr[AW+1:2]; addr[1:0] SHALL be ignored.
REQ-014 SHALL define a request as out-of-range when addr[31:AW+2]!=0.
REQ-015 SHALL implement a state machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE->BUSY on accept when LATENCY>1, loading counter with LATENCY-2.
- IDLE->RESP on accept when LATENCY=1.
- BUSY: decrement counter each cycle; go to RESP when counter=0.
- RESP->IDLE unconditionally after one cycle.
REQ-016 SHALL assert dresp.data_ok=1 for exactly one cycle, in RESP at cycle T+LATENCY.
REQ-017 SHALL, on an in-range read, drive dresp.data = the full stored word in the RESP cycle.
REQ-018 SHALL, on an in-range write, update each byte lane i where strobe[i]=1 with data[8i+7:8i] at the end of the RESP cycle; other lanes SHALL be unchanged.
REQ-019 SHALL, on a write, drive dresp.data=0 in the RESP cycle.
REQ-020 SHALL, on an out-of-range request:
- complete the normal handshake and timing;
- return data 0 on a read;
- drop a write;
- increment err_cnt in the RESP cycle, saturating at 8'hFF.
REQ-021 SHALL drive dresp.data=0 whenever data_ok=0.
REQ-022 SHALL, for a read issued after a write to the same word has received data_ok, return the written value.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, go to IDLE, clear the counter, clear err_cnt to 0, and discard any outstanding request without data_ok.
REQ-024 SHALL output reset values in the cycle after reset: addr_ok=1, data_ok=0, data=0, err_cnt=0.
REQ-025 SHALL apply no write whose RESP cycle coincides with reset=1.
REQ-026 SHALL leave store contents unaffected by reset; store contents before any write are undefined.

Verification
REQ-027 SHALL cover write then read: write addr 0x10, strobe 4'hF, data 0xDEADBEEF, then read addr 0x10 -> data_ok at T+2 for each; read data 0xDEADBEEF.
REQ-028 SHALL cover a partial write: word holds 0x11223344; write strobe 4'h2, data 0x0000AA00 to the same word -> subsequent read returns 0x1122AA44.
REQ-029 SHALL cover held valid: valid held high back-to-back, LATENCY=2 -> accepts at cycles 0, 3, 6; addr_ok low in cycles 1-2 and 4-5; data_ok in cycles 2, 5, 8.
REQ-030 SHALL cover out of range: MEM_WORDS=1024, read addr 0x00001000 -> data 0, err_cnt 1; then 300 such requests -> err_cnt 0xFF.
REQ-031 SHALL cover reset mid-operation: reset asserted in the cycle after accepting a write -> no data_ok, word unchanged, addr_ok=1 the next cycle.
REQ-032 SHALL cover LATENCY=1: read accepted at T -> data_ok at T+1, addr_ok again at T+2.
